// File: rtl/fiat_25519_mul_small_arb.sv
// Round-robin arbiter that time-shares one signed(32) x unsigned(6) multiplier
// among NUM_REQ requesters, with a single registered output slot.
module fiat_25519_mul_small_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*6-1:0]    req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [ID_WIDTH-1:0]     rsp_id,
  output logic [15:0]             op_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         data_q, data_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ID_WIDTH-1:0] rr_q, rr_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                can_issue;
  logic                grant_found;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                accept;
  logic [31:0]         a_sel;
  logic [5:0]          b_sel;
  logic signed [38:0]  prod_full;

  // The slot can take a new operand when it is empty or is being drained now.
  assign can_issue = (state_q == EMPTY) || rsp_ready;

  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    // First pass: lowest valid index at or above the pointer.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (ID_WIDTH'(i) >= rr_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(i);
      end
    end
    // Second pass wraps around to the lowest valid index overall.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = !ap_rst && can_issue && grant_found && (grant_idx == ID_WIDTH'(i));
    end
  end

  assign req_ready = grant_oh;
  assign accept    = |grant_oh;

  // One-hot operand mux feeding the single shared multiplier.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        a_sel = req_a[32*i +: 32];
        b_sel = req_b[6*i +: 6];
      end
    end
  end

  // The leading zero keeps b non-negative in the signed product.
  assign prod_full = $signed(a_sel) * $signed({1'b0, b_sel});

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = FULL;
      data_d  = prod_full[31:0];
      id_d    = grant_idx;
      rr_d    = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
      cnt_d   = cnt_q + 16'd1;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_fiat_25519_mul_small_arb.sv
// Self-checking bench: reference model of the arbiter plus a result scoreboard,
// table-driven product vectors and hand-written sequences for corner cases.
module tb_fiat_25519_mul_small_arb;

  localparam int N  = 4;
  localparam int IW = 2;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a;
  logic [N*6-1:0]    req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [IW-1:0]     rsp_id;
  logic [15:0]       op_count;

  fiat_25519_mul_small_arb #(.NUM_REQ(N), .ID_WIDTH(IW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [5:0]  b;
    logic [31:0] exp;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  logic [31:0] a_arr[N];
  logic [5:0]  b_arr[N];
  logic [3:0]  last_ready;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  int          m_rr;
  bit          m_full;
  logic [15:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [5:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({58'd0, b});
    return p[31:0];
  endfunction

  function automatic int model_grant(input logic [3:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a_arr[i];
      req_b[6*i +: 6]   = b_arr[i];
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic cycle(input logic [3:0] v, input logic rr);
    int         g;
    logic [3:0] exp_ready;
    exp_t       e;
    @(negedge ap_clk);
    req_valid = v;
    rsp_ready = rr;
    pack_inputs();
    #1;
    g         = -1;
    exp_ready = '0;
    if (!m_full || rr) begin
      g = model_grant(v, m_rr);
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    last_ready = req_ready;
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, m_full);
    check("op_count", op_count, m_cnt);
    if (m_full) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: rsp pending but no expected entry at %0t", $time);
      end else begin
        check("rsp_data", rsp_data, sb[0].data);
        check("rsp_id", rsp_id, sb[0].id);
        if (rr) void'(sb.pop_front());
      end
    end
    if (g >= 0) begin
      e.data = mul_ref(a_arr[g], b_arr[g]);
      e.id   = g[1:0];
      sb.push_back(e);
      m_full = 1'b1;
      m_rr   = (g + 1) % N;
      m_cnt  = m_cnt + 16'd1;
    end else if (m_full && rr) begin
      m_full = 1'b0;
    end
  endtask

  task automatic pulse_reset(input logic [3:0] v);
    @(negedge ap_clk);
    ap_rst    = 1'b1;
    req_valid = v;
    rsp_ready = 1'b1;
    #1;
    check("ready_in_reset", req_ready, '0);
    @(posedge ap_clk);
    #1;
    m_full = 1'b0;
    m_rr   = 0;
    m_cnt  = '0;
    sb.delete();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_op_count", op_count, 16'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_id", rsp_id, '0);
    ap_rst    = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    ap_rst     = 1'b1;
    req_valid  = '0;
    rsp_ready  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    last_ready = '0;
    m_full     = 1'b0;
    m_rr       = 0;
    m_cnt      = '0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end

    vecs[0] = '{a: 32'h7FFFFFFF, b: 6'd38, exp: 32'hFFFFFFDA};
    vecs[1] = '{a: 32'h80000000, b: 6'd63, exp: 32'h80000000};
    vecs[2] = '{a: 32'hFFFFFFFF, b: 6'd63, exp: 32'hFFFFFFC1};
    vecs[3] = '{a: 32'h00000005, b: 6'd0,  exp: 32'h00000000};
    vecs[4] = '{a: 32'h12345678, b: 6'd19, exp: 32'h59E26AE8};
    vecs[5] = '{a: 32'hFFFFFFFE, b: 6'd19, exp: 32'hFFFFFFDA};

    repeat (2) @(posedge ap_clk);
    pulse_reset(4'b0000);

    // Product table, one requester at a time
    for (int k = 0; k < 6; k++) begin
      int idx;
      idx        = k % N;
      a_arr[idx] = vecs[k].a;
      b_arr[idx] = vecs[k].b;
      cycle(4'(1 << idx), 1'b1);
      @(posedge ap_clk);
      #1;
      check("vec_valid", rsp_valid, 1'b1);
      check("vec_data", rsp_data, vecs[k].exp);
      check("vec_id", rsp_id, 32'(idx));
      if (k == 0) check("single_op_count", op_count, 16'd1);
    end
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Fairness: all valid, consumer always ready
    for (int i = 0; i < N; i++) begin
      a_arr[i] = $urandom;
      b_arr[i] = 6'($urandom_range(0, 63));
    end
    for (int k = 0; k < 12; k++) cycle(4'b1111, 1'b1);

    // Backpressure with operands changing after they were accepted
    for (int k = 0; k < 5; k++) begin
      a_arr[k % N] = $urandom;
      cycle(4'b1111, 1'b0);
    end
    cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Reset while FULL with op_count = 7
    pulse_reset(4'b0000);
    for (int k = 0; k < 7; k++) cycle(4'b1111, 1'b1);
    @(posedge ap_clk);
    #1;
    check("pre_reset_count", op_count, 16'd7);
    check("pre_reset_full", rsp_valid, 1'b1);
    pulse_reset(4'b1111);
    cycle(4'b1010, 1'b1);
    check("first_grant_after_reset", last_ready, 4'b0010);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // op_count wrap, then grant from pointer 3 wraps to requester 0
    pulse_reset(4'b0000);
    for (int k = 0; k < 65536; k++) cycle(4'b1111, 1'b1);
    @(posedge ap_clk);
    #1;
    check("wrap_count", op_count, 16'h0000);
    for (int k = 0; k < 3; k++) cycle(4'b1111, 1'b1);
    cycle(4'b0101, 1'b1);
    check("wrap_rr_grant", last_ready, 4'b0001);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
